// File: rtl/pr_bus_arbiter_if.sv
// ============================================================================
//  Module      : pr_bus_arbiter_if
//  Description : Bundles the processor-side peripheral bus. It carries the
//                CPU bridge port, the secondary DMA master port and the shared
//                device port of the two timer-class devices.
//                  master : bus-master side view (CPU, DMA, device bank)
//                  slave  : arbiter view
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pr_bus_arbiter_if;
    // CPU bridge port
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic        cpu_we;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    // Secondary DMA master port
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic        dma_we;
    logic [31:0] dma_rd;
    logic        dma_ack;
    // Shared device port
    logic [31:0] dev_addr;
    logic [31:0] dev_wd;
    logic        dev_we0;
    logic        dev_we1;
    logic [31:0] dev_rd0;
    logic [31:0] dev_rd1;

    modport master (
        output cpu_req, cpu_addr, cpu_wd, cpu_we,
        input  cpu_rd, cpu_stall,
        output dma_req, dma_addr, dma_wd, dma_we,
        input  dma_rd, dma_ack,
        input  dev_addr, dev_wd, dev_we0, dev_we1,
        output dev_rd0, dev_rd1
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_wd, cpu_we,
        output cpu_rd, cpu_stall,
        input  dma_req, dma_addr, dma_wd, dma_we,
        output dma_rd, dma_ack,
        output dev_addr, dev_wd, dev_we0, dev_we1,
        input  dev_rd0, dev_rd1
    );
endinterface

`default_nettype wire

// File: rtl/pr_bus_arbiter.sv
// ============================================================================
//  Module      : pr_bus_arbiter
//  Description : Shares the processor peripheral bus between the CPU bridge
//                and a DMA-style master, and decodes each granted access to
//                one of two timer-class devices.
//  Ports       : clk      - system clock
//                reset    - asynchronous, active-high reset
//                bus      - pr_bus_arbiter_if.slave (CPU, DMA, device ports)
//                bus_err  - sticky unmapped-access flag   (PR_BUS_ARB_ERR_EN)
//                err_addr - first unmapped address        (PR_BUS_ARB_ERR_EN)
//  Options     : define PR_BUS_ARB_ERR_EN to add the bus_err/err_addr outputs
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pr_bus_arbiter #(
    parameter logic [31:0] DEV0_BASE     = 32'h0000_7f00,
    parameter logic [31:0] DEV1_BASE     = 32'h0000_7f10,
    parameter int unsigned DEV_SPAN      = 12,
    parameter int unsigned DMA_MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,
    pr_bus_arbiter_if.slave bus
`ifdef PR_BUS_ARB_ERR_EN
    ,
    output logic            bus_err,
    output logic [31:0]     err_addr
`endif
);

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam logic [3:0]  BURST_LAST = 4'(DMA_MAX_BURST - 1);
    localparam logic [3:0]  CNT_MAX    = 4'hF;
    localparam logic [31:0] SPAN       = 32'(DEV_SPAN);

    owner_e      owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        sel_req;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic [31:0] sel_rd;
    logic        hit0;
    logic        hit1;

    // ------------------------------------------------------------------
    // Owner-selected bus mux and address decode
    // ------------------------------------------------------------------
    always_comb begin
        if (owner_q == OWN_DMA) begin
            sel_req  = bus.dma_req;
            sel_we   = bus.dma_we;
            sel_addr = bus.dma_addr;
            sel_wd   = bus.dma_wd;
        end else begin
            sel_req  = bus.cpu_req;
            sel_we   = bus.cpu_we;
            sel_addr = bus.cpu_addr;
            sel_wd   = bus.cpu_wd;
        end

        // Offset form of base <= a < base+span: an address below the base
        // wraps to a huge offset and fails the compare.
        hit0 = (sel_addr - DEV0_BASE) < SPAN;
        hit1 = (sel_addr - DEV1_BASE) < SPAN;

        if (hit0) begin
            sel_rd = bus.dev_rd0;
        end else if (hit1) begin
            sel_rd = bus.dev_rd1;
        end else begin
            sel_rd = '0;
        end
    end

    assign bus.dev_addr = {sel_addr[31:2], 2'b00};
    assign bus.dev_wd   = sel_wd;
    assign bus.dev_we0  = sel_req & sel_we & hit0;
    assign bus.dev_we1  = sel_req & sel_we & hit1;

    // ------------------------------------------------------------------
    // Ownership FSM: next state and per-master handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        bus.cpu_stall = 1'b0;
        bus.cpu_rd    = '0;
        bus.dma_ack   = 1'b0;
        bus.dma_rd    = '0;

        case (owner_q)
            OWN_CPU: begin
                bus.cpu_rd = bus.cpu_req ? sel_rd : '0;
                // CPU has priority; the DMA only takes an idle bus.
                if (bus.dma_req && !bus.cpu_req) begin
                    owner_d = OWN_DMA;
                    cnt_d   = '0;
                end
            end
            OWN_DMA: begin
                bus.dma_ack   = bus.dma_req;
                bus.dma_rd    = sel_rd;
                bus.cpu_stall = bus.cpu_req;
                if (bus.dma_req && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 4'd1;
                end
                // cnt saturates during an unbounded burst, so a CPU arriving
                // late must still win as soon as the limit has been reached:
                // the compare is >= rather than ==.
                if (!bus.dma_req) begin
                    owner_d = OWN_CPU;
                end else if (bus.cpu_req && (cnt_q >= BURST_LAST)) begin
                    owner_d = OWN_CPU;
                end
            end
            default: begin
                owner_d = OWN_CPU;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_CPU;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PR_BUS_ARB_ERR_EN
    // ------------------------------------------------------------------
    // Sticky unmapped-access error; only the first address is kept
    // ------------------------------------------------------------------
    logic        bus_err_q;
    logic [31:0] err_addr_q;
    logic        unmapped;

    assign unmapped = sel_req & ~hit0 & ~hit1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (unmapped && !bus_err_q) begin
            bus_err_q  <= 1'b1;
            err_addr_q <= sel_addr;
        end
    end

    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pr_bus_arbiter.sv
// ============================================================================
//  Module      : tb_pr_bus_arbiter
//  Description : Self-checking bench for pr_bus_arbiter. Two instances are
//                built: u_a (DMA_MAX_BURST=4) and u_b (DMA_MAX_BURST=1). The
//                instance selected by 'd' receives requests; the other idles.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pr_bus_arbiter;

    localparam logic [31:0] B0   = 32'h0000_7f00;
    localparam logic [31:0] B1   = 32'h0000_7f10;
    localparam logic [31:0] SPAN = 32'd12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int d = 0;

    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wd = '0, dma_addr = '0, dma_wd = '0;

    int checks = 0;
    int errors = 0;

    pr_bus_arbiter_if ba ();
    pr_bus_arbiter_if bb ();

    // Stimulus routing: only the selected instance sees requests.
    assign ba.cpu_req  = cpu_req && (d == 0);
    assign ba.dma_req  = dma_req && (d == 0);
    assign bb.cpu_req  = cpu_req && (d == 1);
    assign bb.dma_req  = dma_req && (d == 1);
    assign ba.cpu_addr = cpu_addr;  assign bb.cpu_addr = cpu_addr;
    assign ba.cpu_wd   = cpu_wd;    assign bb.cpu_wd   = cpu_wd;
    assign ba.cpu_we   = cpu_we;    assign bb.cpu_we   = cpu_we;
    assign ba.dma_addr = dma_addr;  assign bb.dma_addr = dma_addr;
    assign ba.dma_wd   = dma_wd;    assign bb.dma_wd   = dma_wd;
    assign ba.dma_we   = dma_we;    assign bb.dma_we   = dma_we;

    // ------------------------------------------------------------------
    // Device bank models: three words each, combinational read; an
    // out-of-range read returns a marker the arbiter must never forward.
    // ------------------------------------------------------------------
    logic [31:0] dmem [2][2][3] = '{default: '0};

    function automatic logic [31:0] dev_read(input int dd, input int n, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ((n == 1) ? B1 : B0);
        if (off < SPAN) return dmem[dd][n][off[3:2]];
        return 32'hBADB_AD00;
    endfunction

    assign ba.dev_rd0 = dev_read(0, 0, ba.dev_addr);
    assign ba.dev_rd1 = dev_read(0, 1, ba.dev_addr);
    assign bb.dev_rd0 = dev_read(1, 0, bb.dev_addr);
    assign bb.dev_rd1 = dev_read(1, 1, bb.dev_addr);

    function automatic int widx(input logic [31:0] off);
        return int'(off[3:2]);
    endfunction

    always @(posedge clk) begin
        if (ba.dev_we0) dmem[0][0][widx(ba.dev_addr - B0)] <= ba.dev_wd;
        if (ba.dev_we1) dmem[0][1][widx(ba.dev_addr - B1)] <= ba.dev_wd;
        if (bb.dev_we0) dmem[1][0][widx(bb.dev_addr - B0)] <= bb.dev_wd;
        if (bb.dev_we1) dmem[1][1][widx(bb.dev_addr - B1)] <= bb.dev_wd;
    end

`ifdef PR_BUS_ARB_ERR_EN
    logic        a_err, b_err;
    logic [31:0] a_eaddr, b_eaddr;
    pr_bus_arbiter u_a (.clk(clk), .reset(reset), .bus(ba), .bus_err(a_err), .err_addr(a_eaddr));
    pr_bus_arbiter #(.DMA_MAX_BURST(1)) u_b (.clk(clk), .reset(reset), .bus(bb),
                                             .bus_err(b_err), .err_addr(b_eaddr));
`else
    pr_bus_arbiter u_a (.clk(clk), .reset(reset), .bus(ba));
    pr_bus_arbiter #(.DMA_MAX_BURST(1)) u_b (.clk(clk), .reset(reset), .bus(bb));
`endif

    // Observed outputs of the selected instance
    logic [31:0] o_cpu_rd, o_dma_rd, o_dev_addr, o_dev_wd;
    logic        o_stall, o_ack, o_we0, o_we1;
    always_comb begin
        if (d == 0) begin
            o_cpu_rd = ba.cpu_rd;   o_dma_rd = ba.dma_rd;   o_dev_addr = ba.dev_addr;
            o_dev_wd = ba.dev_wd;   o_stall  = ba.cpu_stall; o_ack     = ba.dma_ack;
            o_we0    = ba.dev_we0;  o_we1    = ba.dev_we1;
        end else begin
            o_cpu_rd = bb.cpu_rd;   o_dma_rd = bb.dma_rd;   o_dev_addr = bb.dev_addr;
            o_dev_wd = bb.dev_wd;   o_stall  = bb.cpu_stall; o_ack     = bb.dma_ack;
            o_we0    = bb.dev_we0;  o_we1    = bb.dev_we1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: who holds the bus, beats granted since the DMA took
    // it, expected register contents and the sticky error.
    // ------------------------------------------------------------------
    bit          m_dma   [2] = '{0, 0};
    int          m_beats [2] = '{0, 0};
    int          srun    [2] = '{0, 0};
    int          maxb    [2] = '{4, 1};
    logic [31:0] rmem [2][2][3] = '{default: '0};
    bit          m_err   [2] = '{0, 0};
    logic [31:0] m_eaddr [2] = '{32'h0, 32'h0};
    logic        e_stall = 1'b0, e_ack = 1'b0;
    logic        s_stall, s_ack, s_we0, s_we1;
    logic [31:0] s_cpu_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dma[i] = 0; m_beats[i] = 0; srun[i] = 0; m_err[i] = 0; m_eaddr[i] = '0;
        end
        e_stall = 1'b0; e_ack = 1'b0;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wd = v;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        dma_req = r; dma_we = w; dma_addr = a; dma_wd = v;
    endtask

    // One bus cycle: called just after a falling edge with inputs applied.
    task automatic step(input string tag);
        bit          dow;
        logic        req, we, h0, h1;
        logic [31:0] a, wv, rd;
        int          i0, i1;
        #1;
        dow = m_dma[d];
        a   = dow ? dma_addr : cpu_addr;
        wv  = dow ? dma_wd   : cpu_wd;
        req = dow ? dma_req  : cpu_req;
        we  = dow ? dma_we   : cpu_we;
        h0  = (a - B0) < SPAN;
        h1  = (a - B1) < SPAN;
        i0  = int'((a - B0) >> 2);
        i1  = int'((a - B1) >> 2);
        rd  = h0 ? rmem[d][0][i0] : (h1 ? rmem[d][1][i1] : 32'h0);
        e_stall = dow & cpu_req;
        e_ack   = dow & dma_req;

        s_stall = o_stall; s_ack = o_ack; s_we0 = o_we0; s_we1 = o_we1; s_cpu_rd = o_cpu_rd;
        chk({tag, ".stall"},  32'(o_stall), 32'(e_stall));
        chk({tag, ".ack"},    32'(o_ack),   32'(e_ack));
        chk({tag, ".cpu_rd"}, o_cpu_rd, (!dow && cpu_req) ? rd : 32'h0);
        chk({tag, ".dma_rd"}, o_dma_rd, dow ? rd : 32'h0);
        chk({tag, ".we0"},    32'(o_we0), 32'(req & we & h0));
        chk({tag, ".we1"},    32'(o_we1), 32'(req & we & h1));
        chk({tag, ".addr"},   o_dev_addr, {a[31:2], 2'b00});
        chk({tag, ".wd"},     o_dev_wd, wv);
        srun[d] = o_stall ? srun[d] + 1 : 0;
        chk({tag, ".starve"}, 32'(srun[d] <= maxb[d]), 32'd1);
`ifdef PR_BUS_ARB_ERR_EN
        chk({tag, ".bus_err"},  32'((d == 0) ? a_err : b_err), 32'(m_err[d]));
        chk({tag, ".err_addr"}, (d == 0) ? a_eaddr : b_eaddr, m_eaddr[d]);
`endif
        @(posedge clk);
        if (req && we && h0) rmem[d][0][i0] = wv;
        if (req && we && h1) rmem[d][1][i1] = wv;
        if (req && !h0 && !h1 && !m_err[d]) begin
            m_err[d] = 1; m_eaddr[d] = a;
        end
        if (!dow) begin
            if (dma_req && !cpu_req) begin m_dma[d] = 1; m_beats[d] = 0; end
        end else if (!dma_req) begin
            m_dma[d] = 0;
        end else begin
            m_beats[d]++;
            if (cpu_req && m_beats[d] >= maxb[d]) m_dma[d] = 0;
        end
        @(negedge clk);
    endtask

    logic [31:0] atab [10] = '{32'h7f00, 32'h7f04, 32'h7f08, 32'h7f0c, 32'h7f10,
                               32'h7f14, 32'h7f18, 32'h7f1c, 32'h3000, 32'h7efc};

    initial begin
        int acks, stalls, n;
        bit done;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and a CPU write/read round trip
        step("idle");
        chk("rst_ack", 32'(s_ack), 32'd0);
        set_cpu(1, 1, 32'h7f04, 32'hDEAD_BEEF);
        step("cpu_wr");
        chk("cpu_wr_we0", 32'(s_we0), 32'd1);
        set_cpu(1, 0, 32'h7f04, 32'h0);
        step("cpu_rd");
        chk("cpu_rd_we0", 32'(s_we0), 32'd0);
        chk("cpu_rd_data", s_cpu_rd, 32'hDEAD_BEEF);
        chk("cpu_rd_stall", 32'(s_stall), 32'd0);

        // Simultaneous requests: CPU wins until it drops its request
        set_dma(1, 0, 32'h7f14, 32'h0);
        step("both0");
        chk("both0_ack", 32'(s_ack), 32'd0);
        step("both1");
        chk("both1_ack", 32'(s_ack), 32'd0);
        set_cpu(0, 0, 32'h7f00, 32'h0);
        step("cpu_drop");
        chk("cpu_drop_ack", 32'(s_ack), 32'd0);
        step("dma_in");
        chk("dma_in_ack", 32'(s_ack), 32'd1);
        set_dma(0, 0, 32'h7f14, 32'h0);
        step("dma_off");

        // Ten-beat DMA burst, CPU joins after beat 2
        acks = 0; stalls = 0; n = 0; done = 0;
        while (acks < 10 && n < 60) begin
            set_dma(1, 1, 32'h7f10 + 32'(4 * (acks % 3)), 32'hA000_0000 + 32'(acks));
            set_cpu(acks >= 2 && !done, 0, 32'h7f14, 32'h0);
            step("burst");
            if (s_ack) acks++;
            if (s_stall) stalls++;
            if (cpu_req && !s_stall) done = 1;
            n++;
        end
        set_dma(0, 0, 32'h0, 32'h0);
        set_cpu(0, 0, 32'h0, 32'h0);
        chk("burst_acks", 32'(acks), 32'd10);
        chk("burst_stalls", 32'(stalls), 32'd2);
        chk("burst_cpu_done", 32'(done), 32'd1);
        step("burst_end");

        // Unmapped accesses
        set_cpu(1, 1, 32'h7f0c, 32'h1234_5678);
        step("unm_wr");
        chk("unm_wr_we", 32'({s_we0, s_we1}), 32'd0);
        set_cpu(1, 0, 32'h3000, 32'h0);
        step("unm_rd");
        chk("unm_rd_data", s_cpu_rd, 32'h0);
        set_cpu(0, 0, 32'h0, 32'h0);
        step("unm_idle");
`ifdef PR_BUS_ARB_ERR_EN
        chk("unm_bus_err", 32'(a_err), 32'd1);
        chk("unm_err_addr", a_eaddr, 32'h7f0c);
`endif

        // Asynchronous reset in the middle of a DMA burst (cnt == 2)
        set_dma(1, 1, 32'h7f18, 32'h5555_0000);
        step("rb_grant");
        step("rb_beat0");
        dma_wd = 32'h5555_0001;
        step("rb_beat1");
        dma_wd = 32'h5555_0002;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_ack", 32'(ba.dma_ack), 32'd0);
        chk("rst_async_we1", 32'(ba.dev_we1), 32'd0);
        chk("rst_async_stall", 32'(ba.cpu_stall), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_cpu(1, 0, 32'h7f10, 32'h0);
        step("post_rst_rd");
        chk("post_rst_stall", 32'(s_stall), 32'd0);
        set_cpu(0, 0, 32'h0, 32'h0);
        set_dma(0, 0, 32'h0, 32'h0);
        step("post_rst_idle");

        // DMA_MAX_BURST=1 instance: the CPU never waits more than one cycle
        d = 1;
        step("b_idle");
        set_dma(1, 1, 32'h7f00, 32'h0B00_0000);
        step("b_grant");
        set_cpu(1, 0, 32'h7f04, 32'h0);
        step("b_cont");
        chk("b_stall1", 32'(s_stall), 32'd1);
        chk("b_ack1", 32'(s_ack), 32'd1);
        dma_wd = 32'h0B00_0001;
        step("b_cpu");
        chk("b_cpu_stall", 32'(s_stall), 32'd0);
        for (int k = 0; k < 24; k++) begin
            if (e_ack) dma_wd = $urandom;
            cpu_req = !(cpu_req && !e_stall);
            step("b_alt");
        end
        set_cpu(0, 0, 32'h0, 32'h0);
        set_dma(0, 0, 32'h0, 32'h0);
        step("b_end");

        // Randomized traffic on both instances
        for (int dd = 0; dd < 2; dd++) begin
            d = dd;
            for (int k = 0; k < 300; k++) begin
                if (!(cpu_req && e_stall))
                    set_cpu(($urandom % 3) != 0, $urandom % 2, atab[$urandom % 10], $urandom);
                if (!(dma_req && !e_ack))
                    set_dma(($urandom % 4) != 0, $urandom % 2, atab[$urandom % 10], $urandom);
                step("rand");
            end
            set_cpu(0, 0, 32'h0, 32'h0);
            set_dma(0, 0, 32'h0, 32'h0);
            step("rand_end0");
            step("rand_end1");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
